if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, selects the next PC from the redirect sources (exception entry, ERET, JR, branch, jump, sequential), drives the instruction-memory address and presents `PC_out`/`instr_out`/`OPC_out`/`EXCCODE_out` to the IF/ID pipeline register in the same cycle. It detects fetch address errors, suppresses fetch until the exception is taken, and keeps stall/redirect statistics for debug.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded by reset
- `EXC_ENTRY`, 32'h0000_4180, exception handler address
- `IMEM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IMEM_BYTES`, 32'h0000_1000, size of the legal fetch window in bytes
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `Flush_Data`  in  1  data-hazard stall from hazard unit
- `Flush_Ctrl`  in  1  control-hazard stall from hazard unit
- `EXC_req`  in  1  exception taken by a later stage
- `ERET`, `JR`, `Flag_Branch`, `J`  in  1 each  redirect requests from ID
- `EPC_in`, `JR_target`, `Branch_target`, `J_target`  in  32 each  redirect targets
- `instr_in`  in  32  instruction-memory read data (combinational from `imem_addr`)
- `imem_addr`  out  32  current PC
- `PC_out`  out  32  PC+4 of the fetched instruction
- `instr_out`  out  32  fetched instruction, or NOP (32'h0000_0000) when invalid
- `OPC_out`  out  32  PC of the fetched instruction (for EPC)
- `EXCCODE_out`  out  5  0 = none, 4 = AdEL on fetch
- `fetch_valid`  out  1  `instr_out` is a real instruction
- `stall_cnt`  out  32  cycles with stall held (saturating)
- `redirect_cnt`  out  32  redirects accepted (saturating)

## Operation
- States: BOOT, RUN, EXC_WAIT. Reset -> BOOT, PC=RESET_PC, counters 0.
- BOOT: one bubble cycle (`fetch_valid`=0, NOP, EXCCODE 0, PC held); next state RUN unconditionally unless `rst`.
- RUN next-PC priority: `EXC_req` -> EXC_ENTRY; `ERET` -> `EPC_in`; `JR` -> `JR_target`; `Flag_Branch` -> `Branch_target`; `J` -> `J_target`; `Flush_Data|Flush_Ctrl` -> hold PC; else PC+4 (mod 2^32, wraps).
- Redirects override stall (consistent with IF/ID, which inserts a NOP on JR/branch/ERET regardless of flush).
- Fetch error: PC[1:0]!=0, or PC<IMEM_BASE, or PC>=IMEM_BASE+IMEM_BYTES (compare in 33-bit to avoid overflow). On error in RUN: `instr_out`=NOP, `EXCCODE_out`=4, `fetch_valid`=1 (carries the exception), `OPC_out`=faulting PC. If not stalled and no redirect that cycle -> EXC_WAIT, PC held. If stalled, remain RUN and re-present the same faulting fetch.
- EXC_WAIT: `fetch_valid`=0, NOP, EXCCODE 0, PC held; leaves to RUN only on `EXC_req` (PC=EXC_ENTRY) or `ERET` (PC=`EPC_in`); other redirects and stalls ignored.
- `stall_cnt` increments in RUN when a stall holds PC and no redirect applies; `redirect_cnt` increments on every accepted redirect (RUN or EXC_WAIT). Both saturate at 32'hFFFF_FFFF.
- `rst` mid-operation: dominates all inputs, same result as power-up reset.

## Timing
- `imem_addr`, `PC_out`, `OPC_out`, `instr_out`, `EXCCODE_out`, `fetch_valid`: combinational from PC, state and `instr_in`; valid before the clock edge that loads IF/ID.
- PC, state, counters: registered; redirect takes effect one cycle after request (target visible on `imem_addr` next cycle).
- Reset values: PC=RESET_PC, so `imem_addr`=RESET_PC, `PC_out`=RESET_PC+4, `OPC_out`=RESET_PC, `instr_out`=0, `EXCCODE_out`=0, `fetch_valid`=0, counters 0.
- First real fetch at `imem_addr`=RESET_PC in the second cycle after `rst` deasserts.

## Test plan
- Reset release, no stalls, memory returns 32'h2008_0001 -> cycle 1 bubble, then `OPC_out` 0x3000, 0x3004, 0x3008 on consecutive cycles, `PC_out`=OPC+4.
- `Flush_Data` high 3 cycles at PC 0x3008 -> `imem_addr` stays 0x3008, `stall_cnt`=3, then resumes 0x300C.
- `Flag_Branch`=1, `Branch_target`=0x3100 together with `JR`=1, `JR_target`=0x3200 and `Flush_Ctrl`=1 -> next PC 0x3200, `redirect_cnt`+1, `stall_cnt` unchanged.
- `J_target`=0x3002 -> `EXCCODE_out`=4, NOP, `OPC_out`=0x3002; next cycle EXC_WAIT (`fetch_valid`=0); `JR` ignored; `EXC_req` -> PC 0x4180, RUN.
- Fetch at 0x3FFC -> legal; sequential to 0x4000 -> AdEL; `ERET` with `EPC_in`=0x3010 -> PC 0x3010.
- `rst` asserted while in EXC_WAIT with `EXC_req` high -> PC=0x3000, BOOT, counters 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the
//            program counter, selects the next PC from the redirect sources
//            (exception entry, ERET, JR, branch, jump, sequential), drives the
//            instruction-memory address and presents the fetched instruction
//            to the IF/ID register. It detects fetch address errors (AdEL),
//            suppresses fetch until the exception is taken, and keeps
//            saturating stall/redirect counters for debug.
// Ports    : clk, rst (sync, active-high)
//            Flush_Data, Flush_Ctrl  - stall requests from the hazard unit
//            EXC_req, ERET, JR, Flag_Branch, J - redirect requests
//            EPC_in, JR_target, Branch_target, J_target - redirect targets
//            instr_in    - imem read data (combinational from imem_addr)
//            imem_addr   - current PC
//            PC_out      - PC+4 of the fetched instruction
//            instr_out   - fetched instruction or NOP
//            OPC_out     - PC of the fetched instruction
//            EXCCODE_out - 0 none, 4 AdEL on fetch
//            fetch_valid - instr_out carries a real fetch
//            stall_cnt, redirect_cnt - saturating debug counters
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Flush_Data,
    input  logic        Flush_Ctrl,
    input  logic        EXC_req,
    input  logic        ERET,
    input  logic        JR,
    input  logic        Flag_Branch,
    input  logic        J,
    input  logic [31:0] EPC_in,
    input  logic [31:0] JR_target,
    input  logic [31:0] Branch_target,
    input  logic [31:0] J_target,
    input  logic [31:0] instr_in,
    output logic [31:0] imem_addr,
    output logic [31:0] PC_out,
    output logic [31:0] instr_out,
    output logic [31:0] OPC_out,
    output logic [4:0]  EXCCODE_out,
    output logic        fetch_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    localparam logic [1:0]  S_BOOT     = 2'd0;
    localparam logic [1:0]  S_RUN      = 2'd1;
    localparam logic [1:0]  S_EXC_WAIT = 2'd2;

    localparam logic [31:0] c_NOP      = 32'h0000_0000;
    localparam logic [4:0]  c_EXC_NONE = 5'd0;
    localparam logic [4:0]  c_EXC_ADEL = 5'd4;
    // Window end computed in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] c_IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_stall_inc;
    logic        w_redir_inc;
    logic        w_fetch_err;
    logic        w_stall;

    assign w_stall     = Flush_Data | Flush_Ctrl;
    assign w_fetch_err = (r_pc[1:0] != 2'b00)
                       || ({1'b0, r_pc} <  {1'b0, IMEM_BASE})
                       || ({1'b0, r_pc} >= c_IMEM_END);

    // ------------------------------------------------------------------
    // Fetch-side outputs: purely combinational from PC, state, instr_in
    // ------------------------------------------------------------------
    always_comb begin
        imem_addr   = r_pc;
        PC_out      = r_pc + 32'd4;
        OPC_out     = r_pc;
        instr_out   = c_NOP;
        EXCCODE_out = c_EXC_NONE;
        fetch_valid = 1'b0;
        if (r_state == S_RUN) begin
            // A faulting fetch is still "valid": it carries the AdEL code
            // down the pipe so the exception is raised in order.
            fetch_valid = 1'b1;
            if (w_fetch_err) begin
                EXCCODE_out = c_EXC_ADEL;
            end else begin
                instr_out = instr_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stall_inc = 1'b0;
        w_redir_inc = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Redirects take priority over stalls: IF/ID bubbles the
                // slot on a redirect regardless of flush, so nothing is lost.
                if (EXC_req) begin
                    w_pc_nxt    = EXC_ENTRY;
                    w_redir_inc = 1'b1;
                end else if (ERET) begin
                    w_pc_nxt    = EPC_in;
                    w_redir_inc = 1'b1;
                end else if (JR) begin
                    w_pc_nxt    = JR_target;
                    w_redir_inc = 1'b1;
                end else if (Flag_Branch) begin
                    w_pc_nxt    = Branch_target;
                    w_redir_inc = 1'b1;
                end else if (J) begin
                    w_pc_nxt    = J_target;
                    w_redir_inc = 1'b1;
                end else if (w_stall) begin
                    // Stalled faulting fetch stays in RUN so it is
                    // re-presented once the stall releases.
                    w_stall_inc = 1'b1;
                end else if (w_fetch_err) begin
                    w_state_nxt = S_EXC_WAIT;
                end else begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            S_EXC_WAIT: begin
                // Only the exception entry or a return can resume fetch.
                if (EXC_req) begin
                    w_pc_nxt    = EXC_ENTRY;
                    w_state_nxt = S_RUN;
                    w_redir_inc = 1'b1;
                end else if (ERET) begin
                    w_pc_nxt    = EPC_in;
                    w_state_nxt = S_RUN;
                    w_redir_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, PC and saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_stall_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_stall_inc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_redir_inc && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage. A directed table walks
//            boot, stall, redirect priority, AdEL entry/exit and reset; a
//            random phase compares every output against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_RESET = 32'h0000_3000;
    localparam logic [31:0] c_EXC   = 32'h0000_4180;

    // Flag bit positions in a vector's flag byte
    localparam int c_F_RST = 7;
    localparam int c_F_FD  = 6;
    localparam int c_F_FC  = 5;
    localparam int c_F_EXC = 4;
    localparam int c_F_ERT = 3;
    localparam int c_F_JR  = 2;
    localparam int c_F_BR  = 1;
    localparam int c_F_J   = 0;

    typedef struct {
        logic [7:0]  flags;
        logic [31:0] t1;      // EPC_in / JR_target / J_target
        logic [31:0] t2;      // Branch_target
        logic [31:0] e_addr;
        logic        e_valid;
        logic [4:0]  e_code;
        logic [31:0] e_stall;
        logic [31:0] e_redir;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        Flush_Data, Flush_Ctrl, EXC_req, ERET, JR, Flag_Branch, J;
    logic [31:0] EPC_in, JR_target, Branch_target, J_target;
    logic [31:0] instr_in;
    logic [31:0] imem_addr, PC_out, instr_out, OPC_out;
    logic [4:0]  EXCCODE_out;
    logic        fetch_valid;
    logic [31:0] stall_cnt, redirect_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 = bubble after reset, 1 = fetching,
    // 2 = waiting for the exception to be taken.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_stall;
    logic [31:0] m_redir;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0001} ^ 32'h2008_0000;
    endfunction

    assign instr_in = mem_word(imem_addr);

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .Flush_Data    (Flush_Data),
        .Flush_Ctrl    (Flush_Ctrl),
        .EXC_req       (EXC_req),
        .ERET          (ERET),
        .JR            (JR),
        .Flag_Branch   (Flag_Branch),
        .J             (J),
        .EPC_in        (EPC_in),
        .JR_target     (JR_target),
        .Branch_target (Branch_target),
        .J_target      (J_target),
        .instr_in      (instr_in),
        .imem_addr     (imem_addr),
        .PC_out        (PC_out),
        .instr_out     (instr_out),
        .OPC_out       (OPC_out),
        .EXCCODE_out   (EXCCODE_out),
        .fetch_valid   (fetch_valid),
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    function automatic vec_t mk(input logic [7:0] f, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] ea,
                                input logic ev, input logic [4:0] ec,
                                input logic [31:0] es, input logic [31:0] er);
        vec_t v;
        v.flags = f; v.t1 = t1; v.t2 = t2; v.e_addr = ea; v.e_valid = ev;
        v.e_code = ec; v.e_stall = es; v.e_redir = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst           = v.flags[c_F_RST];
        Flush_Data    = v.flags[c_F_FD];
        Flush_Ctrl    = v.flags[c_F_FC];
        EXC_req       = v.flags[c_F_EXC];
        ERET          = v.flags[c_F_ERT];
        JR            = v.flags[c_F_JR];
        Flag_Branch   = v.flags[c_F_BR];
        J             = v.flags[c_F_J];
        EPC_in        = v.t1;
        JR_target     = v.t1 ^ 32'h0000_0000;
        J_target      = v.t1;
        Branch_target = v.t2;
    endtask

    function automatic bit legal(input logic [31:0] pc);
        longint unsigned p;
        p = longint'(pc);
        return (p % 4 == 0) && (p >= 64'h3000) && (p < 64'h3000 + 64'h1000);
    endfunction

    // Compare every DUT output with what the model predicts for this cycle.
    task automatic chk_model();
        bit fetching;
        bit ok;
        fetching = (m_mode == 1);
        ok       = legal(m_pc);
        chk("imem_addr",    imem_addr,             m_pc);
        chk("PC_out",       PC_out,                m_pc + 32'd4);
        chk("OPC_out",      OPC_out,               m_pc);
        chk("instr_out",    instr_out,             (fetching && ok) ? mem_word(m_pc) : 32'h0);
        chk("EXCCODE_out",  {27'd0, EXCCODE_out},  (fetching && !ok) ? 32'd4 : 32'd0);
        chk("fetch_valid",  {31'd0, fetch_valid},  {31'd0, fetching});
        chk("stall_cnt",    stall_cnt,             m_stall);
        chk("redirect_cnt", redirect_cnt,          m_redir);
    endtask

    task automatic model_tick(input vec_t v);
        logic [31:0] tgt;
        bit          take;
        if (v.flags[c_F_RST]) begin
            m_mode = 0; m_pc = c_RESET; m_stall = 0; m_redir = 0;
            return;
        end
        take = 1'b1;
        tgt  = 32'h0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            if      (v.flags[c_F_EXC]) tgt = c_EXC;
            else if (v.flags[c_F_ERT]) tgt = v.t1;
            else if (m_mode == 2)      take = 1'b0;
            else if (v.flags[c_F_JR])  tgt = v.t1;
            else if (v.flags[c_F_BR])  tgt = v.t2;
            else if (v.flags[c_F_J])   tgt = v.t1;
            else                       take = 1'b0;
            if (take) begin
                m_pc   = tgt;
                m_mode = 1;
                if (m_redir != 32'hFFFF_FFFF) m_redir++;
            end else if (m_mode == 1) begin
                if (v.flags[c_F_FD] || v.flags[c_F_FC]) begin
                    if (m_stall != 32'hFFFF_FFFF) m_stall++;
                end else if (!legal(m_pc)) begin
                    m_mode = 2;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // One clock: drive away from the edge, check, then advance the model.
    task automatic cycle(input vec_t v, input bit use_table);
        @(posedge clk);
        #2;
        apply(v);
        #1;
        chk_model();
        if (use_table) begin
            chk("tbl_addr",  imem_addr,            v.e_addr);
            chk("tbl_valid", {31'd0, fetch_valid}, {31'd0, v.e_valid});
            chk("tbl_code",  {27'd0, EXCCODE_out}, {27'd0, v.e_code});
            chk("tbl_stall", stall_cnt,            v.e_stall);
            chk("tbl_redir", redirect_cnt,         v.e_redir);
        end
        model_tick(v);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] lst [8];
        lst[0] = 32'h3000; lst[1] = 32'h3FFC; lst[2] = 32'h4000; lst[3] = 32'h2FFC;
        lst[4] = 32'h3002; lst[5] = 32'h3100; lst[6] = 32'hFFFF_FFFC;
        lst[7] = 32'h3000 + {$urandom_range(0, 1023), 2'b00};
        return lst[$urandom_range(0, 7)];
    endfunction

    vec_t tbl [26];

    initial begin
        vec_t rv;
        // flags: rst fd fc exc eret jr br j
        tbl[0]  = mk(8'b0000_0000, 0, 0, 32'h3000, 0, 0, 0, 0);
        tbl[1]  = mk(8'b0000_0000, 0, 0, 32'h3000, 1, 0, 0, 0);
        tbl[2]  = mk(8'b0000_0000, 0, 0, 32'h3004, 1, 0, 0, 0);
        tbl[3]  = mk(8'b0100_0000, 0, 0, 32'h3008, 1, 0, 0, 0);
        tbl[4]  = mk(8'b0100_0000, 0, 0, 32'h3008, 1, 0, 1, 0);
        tbl[5]  = mk(8'b0100_0000, 0, 0, 32'h3008, 1, 0, 2, 0);
        tbl[6]  = mk(8'b0000_0000, 0, 0, 32'h3008, 1, 0, 3, 0);
        tbl[7]  = mk(8'b0010_0110, 32'h3200, 32'h3100, 32'h300C, 1, 0, 3, 0);
        tbl[8]  = mk(8'b0000_0000, 0, 0, 32'h3200, 1, 0, 3, 1);
        tbl[9]  = mk(8'b0000_0001, 32'h3002, 0, 32'h3204, 1, 0, 3, 1);
        tbl[10] = mk(8'b0000_0000, 0, 0, 32'h3002, 1, 4, 3, 2);
        tbl[11] = mk(8'b0000_0100, 32'h3300, 0, 32'h3002, 0, 0, 3, 2);
        tbl[12] = mk(8'b0001_0000, 0, 0, 32'h3002, 0, 0, 3, 2);
        tbl[13] = mk(8'b0000_0001, 32'h3FF8, 0, 32'h4180, 1, 4, 3, 3);
        tbl[14] = mk(8'b0000_0000, 0, 0, 32'h3FF8, 1, 0, 3, 4);
        tbl[15] = mk(8'b0000_0000, 0, 0, 32'h3FFC, 1, 0, 3, 4);
        tbl[16] = mk(8'b0000_0000, 0, 0, 32'h4000, 1, 4, 3, 4);
        tbl[17] = mk(8'b0000_0000, 0, 0, 32'h4000, 0, 0, 3, 4);
        tbl[18] = mk(8'b0000_1000, 32'h3010, 0, 32'h4000, 0, 0, 3, 4);
        tbl[19] = mk(8'b0000_0001, 32'h2FFC, 0, 32'h3010, 1, 0, 3, 5);
        tbl[20] = mk(8'b0100_0000, 0, 0, 32'h2FFC, 1, 4, 3, 6);
        tbl[21] = mk(8'b0000_0000, 0, 0, 32'h2FFC, 1, 4, 4, 6);
        tbl[22] = mk(8'b0000_0000, 0, 0, 32'h2FFC, 0, 0, 4, 6);
        tbl[23] = mk(8'b1001_0000, 0, 0, 32'h2FFC, 0, 0, 4, 6);
        tbl[24] = mk(8'b0000_0000, 0, 0, 32'h3000, 0, 0, 0, 0);
        tbl[25] = mk(8'b0000_0000, 0, 0, 32'h3000, 1, 0, 0, 0);

        rv = mk(8'b1000_0000, 0, 0, 0, 0, 0, 0, 0);
        apply(rv);
        repeat (2) @(posedge clk);
        m_mode = 0; m_pc = c_RESET; m_stall = 0; m_redir = 0;

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i], 1'b1);
        end

        for (int i = 0; i < 800; i++) begin
            rv.flags[c_F_RST] = ($urandom_range(0, 99) == 0);
            rv.flags[c_F_FD]  = ($urandom_range(0, 3) == 0);
            rv.flags[c_F_FC]  = ($urandom_range(0, 4) == 0);
            rv.flags[c_F_EXC] = ($urandom_range(0, 11) == 0);
            rv.flags[c_F_ERT] = ($urandom_range(0, 9) == 0);
            rv.flags[c_F_JR]  = ($urandom_range(0, 7) == 0);
            rv.flags[c_F_BR]  = ($urandom_range(0, 7) == 0);
            rv.flags[c_F_J]   = ($urandom_range(0, 7) == 0);
            rv.t1 = pick_target();
            rv.t2 = pick_target();
            cycle(rv, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
